// File: rtl/ss_pkg.sv
// Shared types, ASCII-to-segment table and digit-select patterns for the
// seven-segment scan scheduler.
package ss_pkg;

    typedef logic [6:0] ss_char_t;
    typedef logic [6:0] seg_t;

    localparam logic [3:0] DIG_OFF = 4'b1111;
    localparam logic [3:0] DIG_D0  = 4'b1110;
    localparam logic [3:0] DIG_D1  = 4'b1101;
    localparam logic [3:0] DIG_D2  = 4'b1011;
    localparam logic [3:0] DIG_D3  = 4'b0111;

    function automatic logic [3:0] dig_pat(input logic [1:0] d);
        case (d)
            2'd0:    return DIG_D0;
            2'd1:    return DIG_D1;
            2'd2:    return DIG_D2;
            default: return DIG_D3;
        endcase
    endfunction

    // Segment order {g,f,e,d,c,b,a}; lowercase folds onto uppercase glyphs.
    function automatic seg_t ascii_to_seg(input ss_char_t c);
        ss_char_t u;
        u = (c >= 7'h61 && c <= 7'h7A) ? c - 7'h20 : c;
        case (u)
            7'h2D:   return 7'h40;
            7'h30:   return 7'h3F;
            7'h31:   return 7'h06;
            7'h32:   return 7'h5B;
            7'h33:   return 7'h4F;
            7'h34:   return 7'h66;
            7'h35:   return 7'h6D;
            7'h36:   return 7'h7D;
            7'h37:   return 7'h07;
            7'h38:   return 7'h7F;
            7'h39:   return 7'h6F;
            7'h41:   return 7'h77;
            7'h42:   return 7'h7C;
            7'h43:   return 7'h39;
            7'h44:   return 7'h5E;
            7'h45:   return 7'h79;
            7'h46:   return 7'h71;
            7'h47:   return 7'h3D;
            7'h48:   return 7'h76;
            7'h49:   return 7'h30;
            7'h4A:   return 7'h1E;
            7'h4C:   return 7'h38;
            7'h4E:   return 7'h54;
            7'h4F:   return 7'h3F;
            7'h50:   return 7'h73;
            7'h52:   return 7'h50;
            7'h53:   return 7'h6D;
            7'h54:   return 7'h78;
            7'h55:   return 7'h3E;
            7'h59:   return 7'h6E;
            7'h5F:   return 7'h08;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/ascii_to_ss.sv
// Combinational ASCII to seven-segment decoder.
module ascii_to_ss
    import ss_pkg::*;
(
    input  ss_char_t ch,
    output seg_t     seg
);

    assign seg = ascii_to_seg(ch);

endmodule

// File: rtl/ss_scroll_sched.sv
// Scan scheduler and scroll controller for a 4-digit seven-segment display.
//   state  | meaning
//   OFF    | display disabled, dig all high, ss blank
//   BLANK  | slot start, all digits off (anti-ghosting)
//   DRIVE  | current digit driven with its latched segment pattern
module ss_scroll_sched
    import ss_pkg::*;
#(
    parameter int SCAN_DIV      = 100,
    parameter int BLANK_CYC     = 1,
    parameter int SCROLL_FRAMES = 64,
    parameter int MSG_LEN       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 sw,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [6:0]                 wr_char,
    output logic [6:0]                 ss,
    output logic [3:0]                 dig,
    output logic                       step
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [AW-1:0] pos_q, pos_d;
    seg_t          ss_q, ss_d;
    logic [3:0]    dig_q, dig_d;
    logic          step_q, step_d;
    ss_char_t      msg_q [MSG_LEN];
    ss_char_t      msg_d [MSG_LEN];

    logic          frame_end;
    logic [FW-1:0] period;
    logic [FW:0]   frame_inc;
    logic [AW-1:0] rd_idx;
    ss_char_t      rd_char;
    seg_t          rd_seg;
    logic [31:0]   wr_addr_ext;
    logic          wr_in_range;
    logic          unused_sw;

    assign unused_sw = ^sw[7:5];

    assign rd_idx  = pos_q + AW'(digit_q);
    assign rd_char = msg_q[rd_idx];

    ascii_to_ss u_dec (
        .ch  (rd_char),
        .seg (rd_seg)
    );

    assign wr_addr_ext = 32'(wr_addr);
    assign wr_in_range = wr_addr_ext < 32'(MSG_LEN);

    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) begin
            msg_d[i] = msg_q[i];
        end
        if (wr_en && wr_in_range) begin
            msg_d[wr_addr] = wr_char;
        end
    end

    always_comb begin
        period = FW'(SCROLL_FRAMES >> sw[3:2]);
        if (period == '0) begin
            period = FW'(1);
        end
        frame_inc = {1'b0, frame_q} + (FW + 1)'(1);
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        digit_d   = digit_q;
        frame_d   = frame_q;
        pos_d     = pos_q;
        ss_d      = ss_q;
        dig_d     = dig_q;
        step_d    = 1'b0;
        frame_end = 1'b0;

        if (!sw[0]) begin
            state_d = ST_OFF;
            slot_d  = '0;
            digit_d = '0;
            ss_d    = '0;
            dig_d   = DIG_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    slot_d  = '0;
                    digit_d = '0;
                    ss_d    = '0;
                    dig_d   = DIG_OFF;
                end
                ST_BLANK: begin
                    slot_d = slot_q + SW'(1);
                    if (slot_q == SW'(BLANK_CYC - 1)) begin
                        state_d = ST_DRIVE;
                        ss_d    = rd_seg;
                        dig_d   = dig_pat(digit_q);
                    end else begin
                        ss_d    = '0;
                        dig_d   = DIG_OFF;
                    end
                end
                ST_DRIVE: begin
                    if (slot_q == SW'(SCAN_DIV - 1)) begin
                        state_d   = ST_BLANK;
                        slot_d    = '0;
                        digit_d   = digit_q + 2'd1;
                        ss_d      = '0;
                        dig_d     = DIG_OFF;
                        frame_end = (digit_q == 2'd3);
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    ss_d    = '0;
                    dig_d   = DIG_OFF;
                end
            endcase
        end

        // >= rather than == so a speed change mid-period never skips a step.
        if (frame_end) begin
            if (frame_inc >= {1'b0, period}) begin
                frame_d = '0;
                if (!sw[4]) begin
                    pos_d  = sw[1] ? pos_q - AW'(1) : pos_q + AW'(1);
                    step_d = 1'b1;
                end
            end else begin
                frame_d = frame_inc[FW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            slot_q  <= '0;
            digit_q <= '0;
            frame_q <= '0;
            pos_q   <= '0;
            ss_q    <= '0;
            dig_q   <= DIG_OFF;
            step_q  <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= 7'h20;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            pos_q   <= pos_d;
            ss_q    <= ss_d;
            dig_q   <= dig_d;
            step_q  <= step_d;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= msg_d[i];
            end
        end
    end

    assign ss   = ss_q;
    assign dig  = dig_q;
    assign step = step_q;

endmodule

// File: tb/tb_ss_scroll_sched.sv
// Bench for ss_scroll_sched: time-based reference model plus literal frame checks.
module tb_ss_scroll_sched;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int SF = 2;
    localparam int L  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [6:0] wr_char;
    logic [6:0] ss;
    logic [3:0] dig;
    logic       step;

    ss_scroll_sched #(
        .SCAN_DIV      (SD),
        .BLANK_CYC     (BC),
        .SCROLL_FRAMES (SF),
        .MSG_LEN       (L)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .ss      (ss),
        .dig     (dig),
        .step    (step)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference glyphs for the characters this bench uses.
    function automatic logic [6:0] seg_ref(input logic [6:0] c);
        case (c)
            7'h48:        return 7'h76;
            7'h45, 7'h65: return 7'h79;
            7'h4C:        return 7'h38;
            7'h4F:        return 7'h3F;
            7'h50:        return 7'h73;
            default:      return 7'h00;
        endcase
    endfunction

    // Model: output is a function of the number of edges since enable.
    logic [6:0] m_msg [L];
    int         m_pos, m_frame, m_age, m_p;
    bit         m_run, m_init = 0;
    logic [6:0] e_ss;
    logic [3:0] e_dig;
    logic       e_step;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init  = 1;
            m_pos   = 0;
            m_frame = 0;
            m_run   = 0;
            m_age   = 0;
            for (int i = 0; i < L; i++) m_msg[i] = 7'h20;
            e_ss   = 7'h00;
            e_dig  = 4'hF;
            e_step = 1'b0;
        end else begin
            int u, d, ph;
            e_step = 1'b0;
            if (!sw[0]) begin
                m_run = 0;
                e_ss  = 7'h00;
                e_dig = 4'hF;
            end else begin
                if (!m_run) begin
                    m_run = 1;
                    m_age = 0;
                end else begin
                    m_age++;
                end
                u  = m_age % (4 * SD);
                d  = u / SD;
                ph = u % SD;
                if (m_age > 0 && u == 0) begin
                    m_p = SF >> sw[3:2];
                    if (m_p < 1) m_p = 1;
                    if (m_frame + 1 >= m_p) begin
                        m_frame = 0;
                        if (!sw[4]) begin
                            m_pos  = sw[1] ? (m_pos + L - 1) % L : (m_pos + 1) % L;
                            e_step = 1'b1;
                        end
                    end else begin
                        m_frame++;
                    end
                end
                if (ph < BC) begin
                    e_dig = 4'hF;
                    e_ss  = 7'h00;
                end else begin
                    e_dig = 4'hF & ~(4'b0001 << d);
                    if (ph == BC) e_ss = seg_ref(m_msg[(m_pos + d) % L]);
                end
            end
            if (wr_en && int'(wr_addr) < L) m_msg[wr_addr] = wr_char;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_init) begin
            chk("model_ss", 32'(ss), 32'(e_ss));
            chk("model_dig", 32'(dig), 32'(e_dig));
            chk("model_step", 32'(step), 32'(e_step));
        end
    end

    logic [6:0] ss_log  [0:511];
    logic [3:0] dig_log [0:511];
    logic       step_log[0:511];
    int         j;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            j++;
            ss_log[j]   = ss;
            dig_log[j]  = dig;
            step_log[j] = step;
        end
    endtask

    function automatic int count_steps(input int a, input int b);
        int s = 0;
        for (int k = a; k <= b; k++) s += int'(step_log[k]);
        return s;
    endfunction

    logic [3:0] dig_exp [4];
    logic [6:0] hell    [4];
    logic [6:0] ello    [4];
    logic [6:0] shel    [4];
    string      msg;

    initial begin
        dig_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        hell    = '{7'h76, 7'h79, 7'h38, 7'h38};
        ello    = '{7'h79, 7'h38, 7'h38, 7'h3F};
        shel    = '{7'h00, 7'h76, 7'h79, 7'h38};
        msg     = "HELLO   ";
        sw = 8'h00; wr_en = 1'b0; wr_addr = 3'd0; wr_char = 7'h00; rst_n = 1'b0;
        j = -1;
        repeat (3) @(negedge clk);
        chk("reset_ss", 32'(ss), 32'h00);
        chk("reset_dig", 32'(dig), 32'hF);
        chk("reset_step", 32'(step), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < L; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_char = 7'(msg[i]);
            @(negedge clk);
        end
        wr_en = 1'b0;

        // First frame after enable: H,E,L,L with a blank cycle per slot.
        sw = 8'h01; j = -1;
        run(16);
        for (int k = 0; k < 16; k++) begin
            chk("frame0_dig", 32'(dig_log[k]), (k % 4 == 0) ? 32'hF : 32'(dig_exp[k / 4]));
            chk("frame0_ss", 32'(ss_log[k]), (k % 4 == 0) ? 32'h0 : 32'(hell[k / 4]));
        end

        run(32);
        chk("fwd_step_count", 32'(count_steps(16, 32)), 32'd1);
        chk("fwd_step_edge", 32'(step_log[32]), 32'd1);
        for (int k = 0; k < 4; k++) chk("fwd_ss", 32'(ss_log[33 + 4 * k]), 32'(ello[k]));

        sw = 8'h03;
        run(64);
        chk("rev_step64", 32'(step_log[64]), 32'd1);
        chk("rev_step96", 32'(step_log[96]), 32'd1);
        for (int k = 0; k < 4; k++) chk("rev_ss", 32'(ss_log[97 + 4 * k]), 32'(shel[k]));

        sw = 8'h11;
        run(160);
        chk("pause_steps", 32'(count_steps(112, 271)), 32'd0);
        for (int k = 0; k < 4; k++) chk("pause_ss", 32'(ss_log[257 + 4 * k]), 32'(shel[k]));
        sw = 8'h01;
        run(17);
        chk("resume_nostep", 32'(count_steps(272, 287)), 32'd0);
        chk("resume_step", 32'(step_log[288]), 32'd1);

        run(2);
        chk("drive_before_off", 32'(dig_log[290]), 32'hE);
        sw = 8'h00;
        run(1);
        chk("off_dig", 32'(dig_log[291]), 32'hF);
        chk("off_ss", 32'(ss_log[291]), 32'h0);
        run(4);

        sw = 8'h0D; j = -1;
        run(49);
        chk("reen_blank", 32'(dig_log[0]), 32'hF);
        chk("reen_dig", 32'(dig_log[1]), 32'hE);
        chk("reen_ss", 32'(ss_log[1]), 32'h76);
        chk("fast_step16", 32'(step_log[16]), 32'd1);
        chk("fast_step32", 32'(step_log[32]), 32'd1);
        chk("fast_step48", 32'(step_log[48]), 32'd1);
        chk("fast_count", 32'(count_steps(0, 48)), 32'd3);

        // Overwrite the character under the active digit mid-slot.
        sw = 8'h1D;
        run(1);
        chk("wr_pre_ss", 32'(ss_log[49]), 32'h38);
        wr_en = 1'b1; wr_addr = 3'd3; wr_char = 7'h50;
        run(1);
        wr_addr = 3'd4; wr_char = 7'h65;
        run(1);
        wr_addr = 3'd5; wr_char = 7'h21;
        run(1);
        wr_en = 1'b0;
        run(26);
        chk("wr_hold50", 32'(ss_log[50]), 32'h38);
        chk("wr_hold51", 32'(ss_log[51]), 32'h38);
        chk("wr_new_p", 32'(ss_log[65]), 32'h73);
        chk("wr_lower_e", 32'(ss_log[69]), 32'h79);
        chk("wr_bang", 32'(ss_log[73]), 32'h00);
        chk("wr_space", 32'(ss_log[77]), 32'h00);

        // Asynchronous reset mid-drive.
        chk("pre_reset_dig", 32'(dig_log[78]), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ss", 32'(ss), 32'h00);
        chk("async_dig", 32'(dig), 32'hF);
        sw = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_char = 7'h48;
        @(negedge clk);
        wr_en = 1'b0;
        sw = 8'h01; j = -1;
        run(8);
        chk("post_reset_pos0", 32'(ss_log[1]), 32'h76);
        chk("post_reset_msg", 32'(ss_log[5]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
